// File: rtl/rvm_lsu_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
// req/gnt handshake for the request phase, rvalid for the response phase.
interface rvm_lsu_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic            gnt;
    logic            wen;
    logic [XLEN-1:0] addr;
    logic [3:0]      strb;
    logic [XLEN-1:0] wdata;
    logic            rvalid;
    logic [XLEN-1:0] rdata;
    logic            error;

    modport master (
        output req, wen, addr, strb, wdata,
        input  gnt, rvalid, rdata, error
    );

    modport slave (
        input  req, wen, addr, strb, wdata,
        output gnt, rvalid, rdata, error
    );
endinterface

// File: rtl/rvm_lsu.sv
// Load/store unit: one memory access per control request. Checks alignment,
// runs the req/gnt/rvalid bus handshake, places store data on byte lanes and
// extracts/extends load data, then reports completion with a one-cycle pulse.
module rvm_lsu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            ctrl_req,
    input  logic            ctrl_we,
    input  logic [1:0]      ctrl_size,
    input  logic            ctrl_signed,
    input  logic [XLEN-1:0] ctrl_addr,
    input  logic [XLEN-1:0] ctrl_wdata,
    output logic            ctrl_busy,
    output logic            ctrl_done,
    output logic            ctrl_err,
    output logic [XLEN-1:0] ctrl_rdata,
    rvm_lsu_if.master       mem
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t     state;
    logic       lat_we;
    logic [1:0] lat_size;
    logic       lat_signed;
    logic [1:0] lat_off;
    logic       accept;

    assign accept = (state == IDLE) && ctrl_req;

    // Size 11 is illegal; halves need an even address, words a 4-byte aligned one.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_strb(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicating across lanes lets the strobes alone select the written bytes.
    function automatic logic [XLEN-1:0] lane_wdata(input logic [1:0] size, input logic [XLEN-1:0] wdata);
        case (size)
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] load_extend(input logic [1:0] size, input logic sgn,
                                                    input logic [1:0] off, input logic [XLEN-1:0] rdata);
        logic [XLEN-1:0] sh;
        sh = rdata >> {off, 3'b000};
        case (size)
            2'b00:   return sgn ? {{(XLEN-8){sh[7]}}, sh[7:0]} : {{(XLEN-8){1'b0}}, sh[7:0]};
            2'b01:   return sgn ? {{(XLEN-16){sh[15]}}, sh[15:0]} : {{(XLEN-16){1'b0}}, sh[15:0]};
            default: return rdata;
        endcase
    endfunction

    // Hold the request attributes needed after the bus phase (load extraction).
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_we     <= ctrl_we;
            lat_size   <= ctrl_size;
            lat_signed <= ctrl_signed;
            lat_off    <= ctrl_addr[1:0];
        end
    end

    // Access sequencer with all control and bus outputs registered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            ctrl_busy  <= 1'b0;
            ctrl_done  <= 1'b0;
            ctrl_err   <= 1'b0;
            ctrl_rdata <= '0;
            mem.req    <= 1'b0;
            mem.wen    <= 1'b0;
            mem.addr   <= '0;
            mem.strb   <= 4'b0000;
            mem.wdata  <= '0;
        end else begin
            ctrl_done <= 1'b0;
            ctrl_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (ctrl_req) begin
                        ctrl_busy <= 1'b1;
                        if (misaligned(ctrl_size, ctrl_addr[1:0])) begin
                            // Rejected without touching the bus.
                            state     <= DONE;
                            ctrl_done <= 1'b1;
                            ctrl_err  <= 1'b1;
                        end else begin
                            state      <= REQ;
                            ctrl_rdata <= '0;
                            mem.req    <= 1'b1;
                            mem.wen    <= ctrl_we;
                            mem.addr   <= {ctrl_addr[XLEN-1:2], 2'b00};
                            mem.strb   <= lane_strb(ctrl_size, ctrl_addr[1:0]);
                            mem.wdata  <= ctrl_we ? lane_wdata(ctrl_size, ctrl_wdata) : '0;
                        end
                    end
                end
                REQ: begin
                    // Bus outputs hold until the slave grants.
                    if (mem.gnt) begin
                        state     <= WAIT;
                        mem.req   <= 1'b0;
                        mem.wen   <= 1'b0;
                        mem.addr  <= '0;
                        mem.strb  <= 4'b0000;
                        mem.wdata <= '0;
                    end
                end
                WAIT: begin
                    if (mem.rvalid) begin
                        state     <= DONE;
                        ctrl_done <= 1'b1;
                        ctrl_err  <= mem.error;
                        if (!lat_we) begin
                            ctrl_rdata <= mem.error ? '0
                                        : load_extend(lat_size, lat_signed, lat_off, mem.rdata);
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    ctrl_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rvm_lsu.sv
// Bench for rvm_lsu: directed scenarios plus a small randomized load sweep.
// Completions are checked by a scoreboard queue filled as requests are issued.
module tb_rvm_lsu;

    logic        clk;
    logic        resetn;
    logic        ctrl_req;
    logic        ctrl_we;
    logic [1:0]  ctrl_size;
    logic        ctrl_signed;
    logic [31:0] ctrl_addr;
    logic [31:0] ctrl_wdata;
    logic        ctrl_busy;
    logic        ctrl_done;
    logic        ctrl_err;
    logic [31:0] ctrl_rdata;

    rvm_lsu_if #(.XLEN(32)) mem ();

    rvm_lsu #(.XLEN(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ctrl_req   (ctrl_req),
        .ctrl_we    (ctrl_we),
        .ctrl_size  (ctrl_size),
        .ctrl_signed(ctrl_signed),
        .ctrl_addr  (ctrl_addr),
        .ctrl_wdata (ctrl_wdata),
        .ctrl_busy  (ctrl_busy),
        .ctrl_done  (ctrl_done),
        .ctrl_err   (ctrl_err),
        .ctrl_rdata (ctrl_rdata),
        .mem        (mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic        chk;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (resetn && ctrl_done) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_done: done=%b with no outstanding request", ctrl_done);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (ctrl_err !== e.err) begin
                    n_fail++;
                    $display("FAIL sb_err: got %b expected %b", ctrl_err, e.err);
                end
                if (e.chk) begin
                    n_tests++;
                    if (ctrl_rdata !== e.rdata) begin
                        n_fail++;
                        $display("FAIL sb_rdata: got %h expected %h", ctrl_rdata, e.rdata);
                    end
                end
            end
        end
    end

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic sgn,
                                               input logic [1:0] off, input logic [31:0] rd);
        logic [7:0]  b [4];
        logic [31:0] r;
        int          o;
        o = int'(off);
        for (int k = 0; k < 4; k++) b[k] = rd[8*k +: 8];
        if (size == 2'b00) begin
            r = {24'h0, b[o]};
            if (sgn && b[o][7]) r[31:8] = 24'hFFFFFF;
        end else if (size == 2'b01) begin
            r = {16'h0, b[o+1], b[o]};
            if (sgn && b[o+1][7]) r[31:16] = 16'hFFFF;
        end else begin
            r = rd;
        end
        return r;
    endfunction

    function automatic logic [3:0] model_strb(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] s;
        int         n;
        n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        s = 4'b0000;
        for (int k = 0; k < 4; k++)
            if (size == 2'b10 || (k >= int'(off) && k < int'(off) + n)) s[k] = 1'b1;
        return s;
    endfunction

    function automatic exp_t mk(input logic err, input logic chk, input logic [31:0] rd);
        exp_t e;
        e.err   = err;
        e.chk   = chk;
        e.rdata = rd;
        return e;
    endfunction

    // Present one request for a single sample edge; returns at the next negedge (T+1).
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        ctrl_we     = we;
        ctrl_size   = size;
        ctrl_signed = sgn;
        ctrl_addr   = addr;
        ctrl_wdata  = wdata;
        ctrl_req    = 1'b1;
        @(negedge clk);
        ctrl_req    = 1'b0;
    endtask

    // Grant after gwait cycles, respond in the following cycle; returns at the done cycle.
    task automatic serve(input int gwait, input logic [31:0] rd, input logic er);
        repeat (gwait) @(negedge clk);
        mem.gnt = 1'b1;
        @(negedge clk);
        mem.gnt    = 1'b0;
        mem.rvalid = 1'b1;
        mem.rdata  = rd;
        mem.error  = er;
        @(negedge clk);
        mem.rvalid = 1'b0;
        mem.error  = 1'b0;
        mem.rdata  = '0;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({ctrl_busy, ctrl_done, ctrl_err, ctrl_rdata} !== 35'h0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got busy=%b done=%b err=%b rdata=%h expected all 0",
                     ctrl_busy, ctrl_done, ctrl_err, ctrl_rdata);
        end
        n_tests++;
        if ({mem.req, mem.wen, mem.addr, mem.strb, mem.wdata} !== 70'h0) begin
            n_fail++;
            $display("FAIL reset_mem: got req=%b wen=%b addr=%h strb=%b wdata=%h expected all 0",
                     mem.req, mem.wen, mem.addr, mem.strb, mem.wdata);
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word_load;
        exp_q.push_back(mk(1'b0, 1'b1, 32'hDEADBEEF));
        issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        n_tests++;
        if ({mem.req, mem.wen, mem.addr, mem.strb, mem.wdata} !== {1'b1, 1'b0, 32'h100, 4'hF, 32'h0}) begin
            n_fail++;
            $display("FAIL word_load_bus: got req=%b wen=%b addr=%h strb=%h wdata=%h expected 1 0 00000100 f 00000000",
                     mem.req, mem.wen, mem.addr, mem.strb, mem.wdata);
        end
        mem.gnt = 1'b1;
        @(negedge clk);
        mem.gnt = 1'b0;
        n_tests++;
        if (mem.req !== 1'b0 || ctrl_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL word_load_wait: got req=%b busy=%b expected 0 1", mem.req, ctrl_busy);
        end
        mem.rvalid = 1'b1;
        mem.rdata  = 32'hDEADBEEF;
        @(negedge clk);
        mem.rvalid = 1'b0;
        n_tests++;
        if (ctrl_done !== 1'b1) begin
            n_fail++;
            $display("FAIL word_load_latency: done at T+3 got %b expected 1", ctrl_done);
        end
        @(negedge clk);
        n_tests++;
        if (ctrl_done !== 1'b0 || ctrl_busy !== 1'b0 || ctrl_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL word_load_after: got done=%b busy=%b rdata=%h expected 0 0 deadbeef",
                     ctrl_done, ctrl_busy, ctrl_rdata);
        end
    endtask

    task automatic test_byte_load;
        for (int s = 1; s >= 0; s--) begin
            exp_q.push_back(mk(1'b0, 1'b1, (s == 1) ? 32'hFFFFFF80 : 32'h00000080));
            issue(1'b0, 2'b00, s[0], 32'h203, 32'h0);
            n_tests++;
            if (mem.strb !== 4'b1000 || mem.addr !== 32'h200) begin
                n_fail++;
                $display("FAIL byte_load_lane: got strb=%b addr=%h expected 1000 00000200", mem.strb, mem.addr);
            end
            serve(0, 32'h80112233, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic test_half_store;
        exp_q.push_back(mk(1'b0, 1'b1, 32'h0));
        issue(1'b1, 2'b01, 1'b0, 32'h302, 32'h0000ABCD);
        n_tests++;
        if ({mem.req, mem.wen, mem.addr, mem.strb, mem.wdata} !== {1'b1, 1'b1, 32'h300, 4'b1100, 32'hABCDABCD}) begin
            n_fail++;
            $display("FAIL half_store_bus: got req=%b wen=%b addr=%h strb=%b wdata=%h expected 1 1 00000300 1100 abcdabcd",
                     mem.req, mem.wen, mem.addr, mem.strb, mem.wdata);
        end
        serve(0, 32'h55555555, 1'b0);
        n_tests++;
        if (ctrl_done !== 1'b1) begin
            n_fail++;
            $display("FAIL half_store_done: got %b expected 1", ctrl_done);
        end
        @(negedge clk);
    endtask

    task automatic test_misaligned;
        logic [1:0]  sz [2];
        logic [31:0] ad [2];
        sz[0] = 2'b10; ad[0] = 32'h101;
        sz[1] = 2'b11; ad[1] = 32'h100;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(mk(1'b1, 1'b0, 32'h0));
            issue(1'b0, sz[i], 1'b0, ad[i], 32'h0);
            n_tests++;
            if (ctrl_done !== 1'b1 || ctrl_err !== 1'b1 || mem.req !== 1'b0) begin
                n_fail++;
                $display("FAIL misaligned_t1_%0d: got done=%b err=%b req=%b expected 1 1 0",
                         i, ctrl_done, ctrl_err, mem.req);
            end
            @(negedge clk);
            n_tests++;
            if (mem.req !== 1'b0 || ctrl_done !== 1'b0 || ctrl_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL misaligned_t2_%0d: got req=%b done=%b busy=%b expected 0 0 0",
                         i, mem.req, ctrl_done, ctrl_busy);
            end
        end
    endtask

    task automatic test_gnt_stall;
        exp_q.push_back(mk(1'b1, 1'b1, 32'h0));
        issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
        for (int c = 0; c < 5; c++) begin
            n_tests++;
            if ({ctrl_busy, mem.req, mem.wen, mem.addr, mem.strb, mem.wdata} !==
                {1'b1, 1'b1, 1'b0, 32'h200, 4'hF, 32'h0}) begin
                n_fail++;
                $display("FAIL gnt_stall_c%0d: got busy=%b req=%b wen=%b addr=%h strb=%h wdata=%h expected 1 1 0 00000200 f 00000000",
                         c, ctrl_busy, mem.req, mem.wen, mem.addr, mem.strb, mem.wdata);
            end
            @(negedge clk);
        end
        serve(0, 32'h12345678, 1'b1);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access;
        issue(1'b0, 2'b10, 1'b0, 32'h500, 32'h0);
        mem.gnt = 1'b1;
        @(negedge clk);
        mem.gnt = 1'b0;
        resetn  = 1'b0;
        #1;
        n_tests++;
        if (mem.req !== 1'b0 || ctrl_busy !== 1'b0 || ctrl_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got req=%b busy=%b done=%b expected 0 0 0", mem.req, ctrl_busy, ctrl_done);
        end
        @(negedge clk);
        resetn     = 1'b1;
        mem.rvalid = 1'b1;
        mem.rdata  = 32'hCAFEF00D;
        @(negedge clk);
        mem.rvalid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            n_tests++;
            if (ctrl_done !== 1'b0 || ctrl_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL late_rvalid_c%0d: got done=%b busy=%b expected 0 0", c, ctrl_done, ctrl_busy);
            end
            @(negedge clk);
        end
        exp_q.push_back(mk(1'b0, 1'b1, 32'hFFFF8001));
        issue(1'b0, 2'b01, 1'b1, 32'h502, 32'h0);
        serve(1, 32'h80011234, 1'b0);
        n_tests++;
        if (ctrl_done !== 1'b1) begin
            n_fail++;
            $display("FAIL after_reset_done: got %b expected 1", ctrl_done);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        exp_q.push_back(mk(1'b0, 1'b1, 32'h00000400));
        issue(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
        // Requests while busy, and gnt outside REQ, must be ignored.
        ctrl_req  = 1'b1;
        ctrl_size = 2'b10;
        ctrl_addr = 32'h101;
        mem.gnt   = 1'b1;
        @(negedge clk);
        mem.rvalid = 1'b1;
        mem.rdata  = 32'h00000400;
        @(negedge clk);
        mem.gnt    = 1'b0;
        mem.rvalid = 1'b0;
        ctrl_req   = 1'b0;
        n_tests++;
        if (ctrl_done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first_done: got %b expected 1", ctrl_done);
        end
        @(negedge clk);
        n_tests++;
        if (ctrl_busy !== 1'b0 || mem.req !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ignored_req: got busy=%b req=%b expected 0 0", ctrl_busy, mem.req);
        end
        exp_q.push_back(mk(1'b0, 1'b1, 32'h000000A5));
        issue(1'b0, 2'b00, 1'b0, 32'h401, 32'h0);
        serve(0, 32'h1234A5FF, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_random_loads;
        for (int i = 0; i < 8; i++) begin
            logic [1:0]  sz;
            logic [1:0]  off;
            logic        sg;
            logic [31:0] rd;
            int          cyc;
            sz  = 2'($urandom_range(0, 2));
            off = (sz == 2'b00) ? 2'($urandom_range(0, 3)) : (sz == 2'b01) ? 2'($urandom_range(0, 1) * 2) : 2'b00;
            sg  = 1'($urandom_range(0, 1));
            rd  = $urandom;
            exp_q.push_back(mk(1'b0, 1'b1, model_load(sz, sg, off, rd)));
            issue(1'b0, sz, sg, 32'h1000 + 32'(i * 16) + {30'h0, off}, 32'h0);
            n_tests++;
            if (mem.strb !== model_strb(sz, off)) begin
                n_fail++;
                $display("FAIL rand_strb_%0d: got %b expected %b", i, mem.strb, model_strb(sz, off));
            end
            serve(int'($urandom_range(0, 2)), rd, 1'b0);
            cyc = 0;
            while (ctrl_busy === 1'b1 && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            if (cyc >= 20) begin
                n_tests++;
                n_fail++;
                $display("FAIL rand_timeout_%0d: busy=%b after 20 cycles expected 0", i, ctrl_busy);
            end
        end
    endtask

    initial begin
        resetn      = 1'b0;
        ctrl_req    = 1'b0;
        ctrl_we     = 1'b0;
        ctrl_size   = 2'b00;
        ctrl_signed = 1'b0;
        ctrl_addr   = '0;
        ctrl_wdata  = '0;
        mem.gnt     = 1'b0;
        mem.rvalid  = 1'b0;
        mem.rdata   = '0;
        mem.error   = 1'b0;

        test_reset;
        test_word_load;
        test_byte_load;
        test_half_store;
        test_misaligned;
        test_gnt_stall;
        test_reset_mid_access;
        test_back_to_back;
        test_random_loads;

        repeat (3) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d completions outstanding expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rvm_lsu.md
Name: rvm_lsu

Overview:
Load/store unit for the multi-cycle core. It sits directly downstream of the control FSM.
- The FSM issues one memory access per request.
- The LSU checks alignment, drives the req/gnt/rvalid data-memory bus, handles byte lanes, and extracts and extends load data.
- It returns a one-cycle done pulse carrying the result to the FSM.

Parameters:
XLEN, 32, data and address width; only 32 is supported.

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
ctrl_req  in  1  start an access; sampled only in IDLE
ctrl_we  in  1  1 = store, 0 = load
ctrl_size  in  2  00 byte, 01 half, 10 word, 11 illegal
ctrl_signed  in  1  sign-extend load result
ctrl_addr  in  XLEN  byte address
ctrl_wdata  in  XLEN  store data, right-justified
ctrl_busy  out  1  high in every state except IDLE
ctrl_done  out  1  one-cycle completion pulse
ctrl_err  out  1  valid with ctrl_done: misaligned, illegal size or bus error
ctrl_rdata  out  XLEN  extended load result; held until the next accepted request
mem_req  out  1  bus request
mem_gnt  in  1  request accepted this cycle
mem_wen  out  1  write enable
mem_addr  out  XLEN  word-aligned address, {addr[31:2],2'b00}
mem_strb  out  4  byte lane enables
mem_wdata  out  XLEN  lane-replicated store data
mem_rvalid  in  1  response valid, for loads and stores
mem_rdata  in  XLEN  read data
mem_error  in  1  bus error, qualified by mem_rvalid

Behaviour:
Reset (async, resetn low):
- State goes to IDLE.
- All outputs are 0; ctrl_rdata is 0.
- Reset asserted mid-access aborts the access and drops mem_req immediately. No done pulse is produced.

States: IDLE, REQ, WAIT, DONE.
- IDLE, ctrl_req=1: latch we, size, signed, addr and wdata.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size=11: go to DONE with err=1. No bus activity.
  - Otherwise: go to REQ.
- REQ: mem_req=1. mem_addr, mem_wen, mem_strb and mem_wdata come from the latched values and stay stable until gnt. On mem_gnt=1, go to WAIT; mem_req drops in the next cycle.
- WAIT: mem_req=0. On mem_rvalid=1, capture err=mem_error; for loads, compute ctrl_rdata. Go to DONE.
- DONE: ctrl_done=1 and ctrl_err valid for exactly one cycle, then go to IDLE.

Request and bus rules:
- ctrl_req is ignored while busy.
- mem_gnt outside REQ and mem_rvalid outside WAIT are ignored.
- gnt and rvalid may arrive in consecutive cycles. rvalid is not accepted in the same cycle as gnt.

Latency, measured from the ctrl_req sample cycle T:
- Best case: done at T+3 (gnt at T+1, rvalid at T+2).
- Misaligned: done at T+1.
- No timeout; the unit waits indefinitely for gnt and rvalid.

Byte lanes (o = addr[1:0]):
- mem_strb: byte = 4'b0001<<o; half = 4'b0011<<o; word = 4'b1111. Driven the same for loads.
- mem_wdata: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata. 0 on loads.

Load extraction:
- sh = mem_rdata >> (8*o).
- byte: sh[7:0]; half: sh[15:0]; word: mem_rdata.
- Zero-extend, or sign-extend when ctrl_signed=1 (ctrl_signed is ignored for word).

ctrl_rdata update:
- On a load with bus error, ctrl_rdata is 0.
- On stores, ctrl_rdata is unchanged.
- On an accepted request it is cleared to 0 in the REQ entry cycle.

Test Plan:
- Word load at 0x100, gnt at 1st REQ cycle, rvalid next with rdata 0xDEADBEEF → ctrl_done at T+3, ctrl_rdata=0xDEADBEEF, err=0, mem_strb=4'hF.
- Signed byte load at 0x203, rdata 0x80112233 → ctrl_rdata 0xFFFFFF80. Same access unsigned → 0x00000080.
- Half store at 0x302, wdata 0x0000ABCD → mem_addr 0x300, strb 4'b1100, wdata 0xABCDABCD, mem_wen=1; done after rvalid.
- Misaligned word load at 0x101, and size=11 → done+err at T+1, mem_req never asserted.
- gnt withheld 5 cycles → mem_req and all mem_* outputs stable, ctrl_busy=1. Then rvalid with mem_error=1 on a load → err=1, ctrl_rdata=0.
- resetn pulsed low while in WAIT → mem_req=0, ctrl_busy=0 immediately, no done pulse. A late rvalid after reset is ignored, and a new request completes normally.
